// File: rtl/bus_pkg.sv
// Shared types and constants for the multiplexed-bus cycle generator family.
// Pure definitions; no logic, no latency, no flow control.
package bus_pkg;

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_T1   = 6'b000010,
        ST_T2   = 6'b000100,
        ST_T3   = 6'b001000,
        ST_TW   = 6'b010000,
        ST_T4   = 6'b100000
    } state_t;

    localparam logic IOM_MEM = 1'b0;
    localparam logic IOM_IO  = 1'b1;

    localparam logic [19:0] CS_BASE_DFLT = 20'h00000;
    localparam logic [19:0] CS_MASK_DFLT = 20'hF0000;

endpackage

// File: rtl/bus_cycle_gen_if.sv
// Request/response port plus multiplexed bus pins of the cycle generator.
// master = the cycle generator, slave = requester and bus-side environment.
interface bus_cycle_gen_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_io;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [15:0]        AD_out;
    logic               AD_oe;
    logic [15:0]        AD_in;
    logic [ADDR_W-17:0] A_HI;
    logic               ALE;
    logic               IOM;
    logic               CS;
    logic               RD;
    logic               WR;
    logic               READY;

    modport master (
        input  req_valid, req_write, req_io, req_addr, req_wdata, AD_in, READY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               AD_out, AD_oe, A_HI, ALE, IOM, CS, RD, WR
    );

    modport slave (
        output req_valid, req_write, req_io, req_addr, req_wdata, AD_in, READY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               AD_out, AD_oe, A_HI, ALE, IOM, CS, RD, WR
    );
endinterface

// File: rtl/bus_addr_decode.sv
// Chip-select decode: cs = ((addr & CS_MASK) == CS_BASE).
// Purely combinational, zero latency, no flow control.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int              ADDR_W  = 20,
    parameter logic [ADDR_W-1:0] CS_BASE = ADDR_W'(CS_BASE_DFLT),
    parameter logic [ADDR_W-1:0] CS_MASK = ADDR_W'(CS_MASK_DFLT)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              cs
);

    assign cs = ((addr & CS_MASK) == CS_BASE);

endmodule

// File: rtl/bus_cycle_gen.sv
// Single-beat request -> T1/T2/T3/Tw*/T4 multiplexed bus cycle; rsp_valid 4+n cycles after accept.
// req_ready only in IDLE (one request in flight); READY low stretches the cycle up to MAX_WAIT Tw.
module bus_cycle_gen
    import bus_pkg::*;
#(
    parameter int                ADDR_W   = 20,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] CS_BASE  = ADDR_W'(CS_BASE_DFLT),
    parameter logic [ADDR_W-1:0] CS_MASK  = ADDR_W'(CS_MASK_DFLT),
    parameter int                MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    bus_cycle_gen_if.master bus
);

    state_t state_q, state_d;
    logic [7:0] wait_q, wait_d;

    logic              write_q, io_q, cs_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept, cs_dec, timeout;
    logic              cur_write, cur_io, cur_cs;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

    logic                ale_d, oe_d, iom_d, cs_d, rd_d, wr_d, rsp_valid_d, rsp_err_d;
    logic [15:0]         ad_out_d;
    logic [ADDR_W-17:0]  a_hi_d;
    logic [DATA_W-1:0]   rsp_rdata_d;

    logic                ale_q, oe_q, iom_q, cs_out_q, rd_q, wr_q, rsp_valid_q, rsp_err_q;
    logic [15:0]         ad_out_q;
    logic [ADDR_W-17:0]  a_hi_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    bus_addr_decode #(
        .ADDR_W  (ADDR_W),
        .CS_BASE (CS_BASE),
        .CS_MASK (CS_MASK)
    ) u_decode (
        .addr (bus.req_addr),
        .cs   (cs_dec)
    );

    assign accept = bus.req_valid && bus.req_ready;

    // T1 outputs are registered on the accept edge, before the holding regs update.
    assign cur_write = accept ? bus.req_write : write_q;
    assign cur_io    = accept ? bus.req_io    : io_q;
    assign cur_cs    = accept ? cs_dec        : cs_q;
    assign cur_addr  = accept ? bus.req_addr  : addr_q;
    assign cur_wdata = accept ? bus.req_wdata : wdata_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        timeout = 1'b0;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (bus.READY) begin
                    state_d = ST_T4;
                end else begin
                    state_d = ST_TW;
                    wait_d  = 8'd1;
                end
            end
            ST_TW: begin
                // READY takes priority over a counter that has just hit the limit.
                if (bus.READY) begin
                    state_d = ST_T4;
                end else if (wait_q == 8'(MAX_WAIT)) begin
                    state_d = ST_T4;
                    timeout = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_T4: begin
                state_d = ST_IDLE;
                wait_d  = 8'd0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ale_d       = 1'b0;
        oe_d        = 1'b0;
        ad_out_d    = 16'h0000;
        a_hi_d      = '0;
        iom_d       = IOM_MEM;
        cs_d        = 1'b0;
        rd_d        = 1'b1;
        wr_d        = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        if (state_d != ST_IDLE) begin
            a_hi_d = cur_addr[ADDR_W-1:16];
            iom_d  = cur_io ? IOM_IO : IOM_MEM;
            cs_d   = cur_cs;
        end
        unique case (state_d)
            ST_T1: begin
                ale_d    = 1'b1;
                oe_d     = 1'b1;
                ad_out_d = cur_addr[15:0];
            end
            ST_T2, ST_T3, ST_TW: begin
                if (cur_write) begin
                    wr_d     = 1'b0;
                    oe_d     = 1'b1;
                    ad_out_d = 16'(cur_wdata);
                end else begin
                    rd_d = 1'b0;
                end
            end
            ST_T4: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = timeout;
                rsp_rdata_d = (timeout || write_q) ? '0 : DATA_W'(bus.AD_in);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= 8'd0;
            write_q     <= 1'b0;
            io_q        <= 1'b0;
            cs_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ale_q       <= 1'b0;
            oe_q        <= 1'b0;
            ad_out_q    <= 16'h0000;
            a_hi_q      <= '0;
            iom_q       <= IOM_MEM;
            cs_out_q    <= 1'b0;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            if (accept) begin
                write_q <= bus.req_write;
                io_q    <= bus.req_io;
                cs_q    <= cs_dec;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            ale_q       <= ale_d;
            oe_q        <= oe_d;
            ad_out_q    <= ad_out_d;
            a_hi_q      <= a_hi_d;
            iom_q       <= iom_d;
            cs_out_q    <= cs_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.AD_out    = ad_out_q;
    assign bus.AD_oe     = oe_q;
    assign bus.A_HI      = a_hi_q;
    assign bus.ALE       = ale_q;
    assign bus.IOM       = iom_q;
    assign bus.CS        = cs_out_q;
    assign bus.RD        = rd_q;
    assign bus.WR        = wr_q;

endmodule

// File: tb/tb_bus_cycle_gen.sv
// Directed bench for bus_cycle_gen: per-cycle strobe checks plus a response scoreboard.
module tb_bus_cycle_gen;

    localparam int MAX_WAIT = 8;

    logic clk;
    logic rst;

    bus_cycle_gen_if #(.ADDR_W(20), .DATA_W(16)) bif ();

    bus_cycle_gen #(
        .ADDR_W   (20),
        .DATA_W   (16),
        .CS_BASE  (20'h00000),
        .CS_MASK  (20'hF0000),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    localparam logic [7:0] IDLE_VEC = 8'b0000_1101;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ALE, AD_oe, IOM, CS, RD, WR, rsp_valid, req_ready}
    function automatic logic [7:0] strobes();
        return {bif.ALE, bif.AD_oe, bif.IOM, bif.CS, bif.RD, bif.WR, bif.rsp_valid, bif.req_ready};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string name);
        exp_t e;
        if (bif.rsp_valid === 1'b1) begin
            chk({name, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({name, "_rsp_rdata"}, 32'(bif.rsp_rdata), 32'(e.rdata));
                chk({name, "_rsp_err"},   32'(bif.rsp_err),   32'(e.err));
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after T4.
    task automatic do_txn(input string name, input logic wr, input logic io,
                          input logic [19:0] addr, input logic [15:0] wd,
                          input int nwait, input logic [15:0] rdv);
        logic       to;
        logic       cs_e;
        int         lat;
        logic [7:0] ev;
        exp_t       e;
        to   = (nwait > MAX_WAIT);
        lat  = 4 + (to ? MAX_WAIT : nwait);
        cs_e = ((addr & 20'hF0000) == 20'h00000);
        e.rdata = (wr || to) ? 16'h0000 : rdv;
        e.err   = to;
        sb.push_back(e);

        bif.req_valid = 1'b1;
        bif.req_write = wr;
        bif.req_io    = io;
        bif.req_addr  = addr;
        bif.req_wdata = wd;
        bif.READY     = 1'b1;
        bif.AD_in     = 16'h0BAD;
        chk({name, "_ready_pre"}, 32'(bif.req_ready), 32'd1);

        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bif.req_valid = 1'b0;
                bif.req_write = ~wr;
                bif.req_io    = ~io;
                bif.req_addr  = ~addr;
                bif.req_wdata = ~wd;
            end
            if (n == 1)        ev = {1'b1, 1'b1, io, cs_e, 1'b1, 1'b1, 1'b0, 1'b0};
            else if (n < lat)  ev = {1'b0, wr, io, cs_e, wr, ~wr, 1'b0, 1'b0};
            else if (n == lat) ev = {1'b0, 1'b0, io, cs_e, 1'b1, 1'b1, 1'b1, 1'b0};
            else               ev = IDLE_VEC;
            chk($sformatf("%s_n%0d_strobes", name, n), 32'(strobes()), 32'(ev));
            if (n == 1) begin
                chk({name, "_t1_ad_out"}, 32'(bif.AD_out), 32'(addr[15:0]));
                chk({name, "_t1_a_hi"},   32'(bif.A_HI),   32'(addr[19:16]));
            end else if (n < lat && wr) begin
                chk($sformatf("%s_n%0d_wdata", name, n), 32'(bif.AD_out), 32'(wd));
            end
            check_rsp(name);
            // READY is low for the first nwait sampling edges of T3/Tw; high (ignored) elsewhere.
            bif.READY = (n >= 3) ? ((n - 3) >= nwait) : 1'b1;
            bif.AD_in = (n >= 2) ? rdv : 16'h0BAD;
        end
    endtask

    initial begin
        rst           = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_write = 1'b0;
        bif.req_io    = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.AD_in     = 16'h0000;
        bif.READY     = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_strobes",   32'(strobes()),      32'(IDLE_VEC));
        chk("reset_rsp_rdata", 32'(bif.rsp_rdata),  32'd0);
        chk("reset_rsp_err",   32'(bif.rsp_err),    32'd0);
        chk("reset_ad_out",    32'(bif.AD_out),     32'd0);
        chk("reset_a_hi",      32'(bif.A_HI),       32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_txn("mem_rd",  1'b0, 1'b0, 20'h01234, 16'h0000, 0,  16'hBEEF);
        do_txn("mem_wr",  1'b1, 1'b0, 20'h00010, 16'hA5A5, 0,  16'h1111);
        do_txn("rd_w3",   1'b0, 1'b0, 20'h0ABCD, 16'h0000, 3,  16'h5A5A);
        do_txn("rd_w8",   1'b0, 1'b0, 20'h0FFFF, 16'h0000, 8,  16'hC0DE);
        do_txn("rd_to",   1'b0, 1'b0, 20'h00F00, 16'h0000, 20, 16'hDEAD);
        do_txn("io_rd",   1'b0, 1'b1, 20'h30000, 16'h0000, 0,  16'h7E57);
        do_txn("io_wr_w2",1'b1, 1'b1, 20'hF0002, 16'h1234, 2,  16'h0000);

        // Reset during T2 of a write: strobes drop at once and the request is lost.
        bif.req_valid = 1'b1;
        bif.req_write = 1'b1;
        bif.req_io    = 1'b0;
        bif.req_addr  = 20'h00020;
        bif.req_wdata = 16'h5555;
        bif.READY     = 1'b1;
        @(negedge clk);
        bif.req_valid = 1'b0;
        chk("rst_t1_ale", 32'(bif.ALE), 32'd1);
        @(negedge clk);
        chk("rst_t2_wr", 32'(bif.WR), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_async_strobes", 32'(strobes()), 32'(IDLE_VEC));
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_strobes", 32'(strobes()), 32'(IDLE_VEC));
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rst_post_idle", 32'(strobes()), 32'(IDLE_VEC));
            check_rsp("rst_post");
        end

        do_txn("post_rst", 1'b0, 1'b0, 20'h04321, 16'h0000, 1, 16'h9876);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_cycle_gen.md
Name: bus_cycle_gen

Overview:
- Bus master that turns single-beat read/write requests into multiplexed-bus cycles (T1, T2, T3, Tw, T4) with ALE, active-low RD/WR, IOM and chip select.
- Sits directly upstream of the memory-side bus-interface FSM. It produces the ALE/CS/IOM/RD/WR strobes that FSM decodes into OE/WD/LoadAddress.
- Returns read data, or a timeout error, to the requester through a valid/ready request port and a one-cycle response pulse.

Parameters:
- ADDR_W, 20, request address width; AD carries addr[15:0], A_HI carries addr[ADDR_W-1:16].
- DATA_W, 16, data width; must equal 16.
- CS_BASE, 20'h00000, decode base compared against masked address.
- CS_MASK, 20'hF0000, decode mask; CS = ((addr & CS_MASK) == CS_BASE).
- MAX_WAIT, 8, maximum wait states before abort; range 1..255.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer occurs when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_io  in  1  1 = I/O space, 0 = memory space.
- req_addr  in  ADDR_W  transaction address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse in T4.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads; 0 on writes and on error.
- rsp_err  out  1  wait-state timeout; qualified by rsp_valid.
- AD_out  out  16  multiplexed address/data drive value.
- AD_oe  out  1  AD output enable.
- AD_in  in  16  AD bus sampled value.
- A_HI  out  ADDR_W-16  upper address.
- ALE  out  1  address latch enable, active-high.
- IOM  out  1  memory/IO select; 0 = memory.
- CS  out  1  decoded chip select, active-high.
- RD  out  1  read strobe, active-low.
- WR  out  1  write strobe, active-low.
- READY  in  1  slave ready; 1 = no further wait.

Behaviour:
- Reset values (while rst = 0):
  - State IDLE, req_ready = 1.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - ALE = 0, IOM = 0, CS = 0, RD = 1, WR = 1.
  - AD_oe = 0, AD_out = 0, A_HI = 0, wait counter = 0.
- Request capture: on accept, latch write, io, addr, wdata and the decoded CS into holding registers. Inputs are don't-care afterwards.
- All bus outputs are registered, driven from the state entered.
- States:
  - IDLE: on accept -> T1.
  - T1 (1 cycle):
    - ALE = 1, AD_oe = 1, AD_out = addr[15:0], A_HI = addr[19:16].
    - IOM and CS valid; RD = WR = 1.
    - -> T2.
  - T2 (1 cycle):
    - ALE = 0.
    - Read: RD = 0, AD_oe = 0.
    - Write: WR = 0, AD_oe = 1, AD_out = wdata.
    - -> T3.
  - T3:
    - Strobe held.
    - READY = 1 -> T4 and capture AD_in into rsp_rdata for reads.
    - READY = 0 -> TW, wait counter = 1.
  - TW:
    - Strobe held.
    - READY = 1 -> T4 with capture.
    - Else if counter == MAX_WAIT -> T4 with rsp_err = 1 and rdata = 0.
    - Else counter++.
  - T4 (1 cycle):
    - RD = WR = 1, AD_oe = 0, ALE = 0.
    - CS and IOM still held.
    - rsp_valid = 1.
    - -> IDLE, where CS = 0 and IOM = 0.
- Latency: accept edge to rsp_valid is 4 cycles with zero waits, 4 + n with n wait states. Minimum spacing between accepts is 5 cycles.
- RD and WR are never low simultaneously. ALE is never high while RD or WR is low.
- CS = 0 (unmapped address) still runs the full cycle; the response is normal with rdata = captured AD_in.
- READY is ignored outside T3 and TW.
- rst asserted mid-cycle: strobes deassert asynchronously, no rsp_valid is issued, and the pending request is dropped.
- A wait counter reaching MAX_WAIT with READY rising in the same cycle counts as success: READY wins.

Decomposition:
- Package bus_pkg holds:
  - One-hot state typedef (IDLE, T1, T2, T3, TW, T4, 6 bits).
  - IOM_MEM = 0 and IOM_IO = 1 constants.
  - Default CS_BASE and CS_MASK.
- One sub-module, bus_addr_decode: combinational CS from addr, CS_BASE and CS_MASK. The same instance type is reused by other masters.

Test Plan:
- Memory read, addr 20'h01234, READY = 1, AD_in = 16'hBEEF:
  - ALE = 1 in T1 with AD_out = 16'h1234, CS = 1, IOM = 0.
  - RD = 0 in T2 and T3.
  - rsp_valid 4 cycles after accept, rsp_rdata = 16'hBEEF, rsp_err = 0.
- Memory write, addr 20'h00010, data 16'hA5A5:
  - WR = 0 in T2 and T3, AD_oe = 1, AD_out = 16'hA5A5; RD stays 1.
  - rsp_valid with rsp_err = 0.
- Read with READY low for 3 cycles:
  - Exactly 3 TW cycles, RD held low.
  - rsp_valid at accept + 7.
- READY held low, MAX_WAIT = 8:
  - Abort after 8 TW cycles.
  - rsp_err = 1, rsp_rdata = 0, RD returns to 1 in T4.
- I/O read to addr 20'h30000: IOM = 1, CS = 0, cycle completes normally.
- rst = 0 asserted during T2 of a write: WR = 1 immediately, no rsp_valid; the next request after release runs a clean T1.
